// File: rtl/hilo_muldiv_unit_pkg.sv
// hilo_muldiv_unit_pkg: HILO op codes, FSM states and sizing helper for the mul/div unit.
package hilo_muldiv_unit_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP   = 3'b111
  } hilo_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;
  function automatic int cnt_width(input int mult_cycles, input int width);
    return $clog2(mult_cycles > width + 1 ? mult_cycles : width + 1);
  endfunction
endpackage

// File: rtl/hilo_muldiv_unit_div_iter.sv
// muldiv_div_iter: restoring divider, one quotient bit per cycle plus a final sign-fix cycle.
module muldiv_div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         signed_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         abort_i,
  output logic         done_o,
  output logic [W-1:0] quo_o,
  output logic [W-1:0] rem_o
);
  localparam int CW = $clog2(W + 1);
  logic          active_q, active_d, qneg_q, qneg_d, rneg_q, rneg_d, ge;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quo_q, quo_d, rem_q, rem_d, div_q, div_d;
  logic [W:0]    shifted;
  always_comb begin
    shifted  = {rem_q, quo_q[W-1]};
    ge       = shifted >= {1'b0, div_q};
    done_o   = active_q && cnt_q == CW'(W);
    active_d = start_i ? 1'b1 : (abort_i || done_o) ? 1'b0 : active_q;
    qneg_d   = start_i ? signed_i & (a_i[W-1] ^ b_i[W-1]) : qneg_q;
    rneg_d   = start_i ? signed_i & a_i[W-1] : rneg_q;
    div_d    = start_i ? ((signed_i && b_i[W-1]) ? -b_i : b_i) : div_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      quo_d = (signed_i && a_i[W-1]) ? -a_i : a_i;
      rem_d = '0;
      cnt_d = '0;
    end else if (active_q && !done_o) begin
      quo_d = {quo_q[W-2:0], ge};
      rem_d = ge ? W'(shifted - {1'b0, div_q}) : shifted[W-1:0];
      cnt_d = cnt_q + 1'b1;
    end
    quo_o = qneg_q ? -quo_q : quo_q;
    rem_o = rneg_q ? -rem_q : rem_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
    end else begin
      active_q <= active_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
    end
  end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO register file with multi-cycle multiply/divide and single-cycle MTHI/MTLO.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = cnt_width(MULT_CYCLES, WIDTH);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, ma_q, mb_q, quo, rem;
  logic               msigned_q, bzero_q, accept, is_mul, is_div, mul_fire, div_fire, div_done;
  logic [2*WIDTH-1:0] ea, eb, prod;
  muldiv_div_iter #(.W(WIDTH)) u_div (
    .clk(clk), .rst(reset), .start_i(accept && is_div), .signed_i(op == OP_DIV),
    .a_i(a), .b_i(b), .abort_i(flush), .done_o(div_done), .quo_o(quo), .rem_o(rem)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ma_q      <= '0;
      mb_q      <= '0;
      msigned_q <= 1'b0;
      bzero_q   <= 1'b0;
    end else if (accept) begin
      ma_q      <= a;
      mb_q      <= b;
      msigned_q <= op == OP_MULT;
      bzero_q   <= b == '0;
    end
  end
  always_comb begin
    is_mul  = op == OP_MULT || op == OP_MULTU;
    is_div  = op == OP_DIV || op == OP_DIVU;
    accept  = start && state_q == ST_IDLE && !flush && op != OP_NOP;
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = (accept && is_mul) ? ST_MUL : (accept && is_div) ? ST_DIV : ST_IDLE;
      ST_MUL:  state_d = (flush || cnt_q == CW'(MULT_CYCLES - 1)) ? ST_IDLE : ST_MUL;
      ST_DIV:  state_d = (flush || div_done) ? ST_IDLE : ST_DIV;
      default: state_d = ST_IDLE;
    endcase
    cnt_d = (state_q == ST_IDLE || state_d == ST_IDLE) ? '0 : cnt_q + 1'b1;
  end
  always_comb begin
    busy     = state_q != ST_IDLE;
    hi       = hi_q;
    lo       = lo_q;
    ea       = msigned_q ? {{WIDTH{ma_q[WIDTH-1]}}, ma_q} : {{WIDTH{1'b0}}, ma_q};
    eb       = msigned_q ? {{WIDTH{mb_q[WIDTH-1]}}, mb_q} : {{WIDTH{1'b0}}, mb_q};
    prod     = ea * eb;
    mul_fire = state_q == ST_MUL && !flush && cnt_q == CW'(MULT_CYCLES - 1);
    div_fire = state_q == ST_DIV && !flush && div_done && !bzero_q;
    hi_d     = mul_fire ? prod[2*WIDTH-1:WIDTH] : div_fire ? rem :
               (accept && op == OP_MTHI) ? a : hi_q;
    lo_d     = mul_fire ? prod[WIDTH-1:0] : div_fire ? quo :
               (accept && op == OP_MTLO) ? a : lo_q;
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and randomized checks of the HI/LO unit against an arithmetic model.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;
  logic        clk = 0, reset = 1, start = 0, flush = 0, busy;
  logic [2:0]  op = OP_NOP;
  logic [31:0] a = 0, b = 0, hi, lo, exp_hi = 0, exp_lo = 0;
  int          n_assert = 0, n_fail = 0;

  hilo_muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output int lat);
    logic signed [63:0] sx, sy, sp, sq, sr;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    eh = exp_hi;
    el = exp_lo;
    lat = 0;
    case (o)
      OP_MULT:  begin sp = sx * sy; {eh, el} = sp; lat = 5; end
      OP_MULTU: begin up = {32'b0, x} * {32'b0, y}; {eh, el} = up; lat = 5; end
      OP_DIV:   begin lat = 33; if (y != 0) begin sq = sx / sy; sr = sx % sy; el = sq[31:0]; eh = sr[31:0]; end end
      OP_DIVU:  begin lat = 33; if (y != 0) begin el = x / y; eh = x % y; end end
      OP_MTHI:  eh = x;
      OP_MTLO:  el = x;
      default:  ;
    endcase
  endtask

  // Issues one op at the current falling edge; poke>0 re-pulses start during that busy cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
    logic [31:0] eh, el;
    int lat, n;
    model(o, x, y, eh, el, lat);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0; op = OP_NOP; n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == poke) begin start = 1; op = OP_DIVU; a = 32'd1000; b = 32'd3; end
      else begin start = 0; op = OP_NOP; end
      @(negedge clk);
    end
    start = 0; op = OP_NOP;
    chk("latency", 64'(n), 64'(lat));
    chk("hi", {32'b0, hi}, {32'b0, eh});
    chk("lo", {32'b0, lo}, {32'b0, el});
    exp_hi = eh;
    exp_lo = el;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    reset = 0;
    run_op(OP_MTHI, 32'h1234, 32'h0, 0);
    run_op(OP_MTLO, 32'hABCD, 32'h0, 0);
    chk("mt_hi", {32'b0, hi}, 64'h1234);
    run_op(OP_MULT, -32'sd3, 32'd7, 0);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 0);
    chk("multu_big", {hi, lo}, 64'h00000001_FFFFFFFE);
    run_op(OP_DIV, -32'sd7, 32'd2, 0);
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(OP_DIVU, 32'd7, 32'd0, 0);
    chk("divu_zero", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
    run_op(OP_MULT, 32'd11, 32'd13, 2);
    chk("busy_start", {hi, lo}, 64'd143);
    // Flush a multiply in its third busy cycle, then a start masked by flush.
    start = 1; op = OP_MULT; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 0; op = OP_NOP;
    repeat (2) @(negedge clk);
    chk("flush_pre_busy", {63'b0, busy}, 64'd1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
    start = 1; op = OP_MULT; a = 32'd9; b = 32'd9; flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_start_busy", {63'b0, busy}, 64'd0);
    run_op(OP_MULT, 32'd9, 32'd9, 0);
    // Reset in the middle of a divide.
    start = 1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 0; op = OP_NOP;
    repeat (10) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_mid_hi", {32'b0, hi}, 64'd0);
    chk("rst_mid_lo", {32'b0, lo}, 64'd0);
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    exp_hi = 0;
    exp_lo = 0;
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      if (ro == 3'b110) ro = OP_NOP;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 0;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20)) * ($urandom_range(0, 1) != 0 ? 32'hFFFFFFFF : 32'd1);
      run_op(ro, ra, rb, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
